prv32_div_unit: RTL
===================

# prv32_div_unit

Iterative 32-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, placed in the execute stage beside the ALU. It replaces the ALU's single-cycle combinational divide and remainder paths. The execute stage hands it the same `a`/`b` operands the ALU sees. It raises `busy` so the hazard unit can stall IF/ID/EX, and it delivers a registered result with a one-cycle `done` pulse for the EX/MEM write-back mux.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-low reset.
- `start`  in  1  — request; sampled only when the unit can accept.
- `flush`  in  1  — pipeline kill; aborts any operation in flight.
- `op`  in  2  — operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a`  in  32  — dividend.
- `b`  in  32  — divisor.
- `busy`  out  1  — high while iterating; the hazard unit stalls on it.
- `done`  out  1  — one-cycle pulse; `r` is valid in the same cycle.
- `r`  out  32  — result (quotient or remainder); holds until the next accepted `start`.

## Operation
- States: IDLE, CALC, DONE.
- Start is accepted when the state is IDLE or DONE, `start`=1 and `flush`=0. On acceptance the unit latches `op`, the sign flags and the operand magnitudes.
- Magnitudes: for DIV/REM, take |a| and |b| in 32-bit unsigned form (|0x80000000| = 0x80000000). For DIVU/REMU, use the operands unchanged.
- Fast path, decided at acceptance; the next state is DONE directly:
  - `b`==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `a`.
  - DIV/REM with `a`=0x80000000 and `b`=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- Normal path: the next state is CALC, with a 5-bit iteration counter at 0.
  - Each CALC edge performs one restoring step on a 33-bit partial remainder P and a 32-bit quotient Q.
  - Step: shift {P,Q} left by one, bring in the dividend MSB, trial-subtract the divisor from P, keep the difference if it is non-negative, and set the Q LSB to the result.
  - After 32 steps, the next state is DONE.
- Sign fix on entering DONE, for signed ops only:
  - Negate the quotient when sign(a)≠sign(b).
  - Negate the remainder when sign(a)=1.
  - Unsigned ops take no correction.
- In DONE, `done`=1 for exactly one cycle. The next state is IDLE, or CALC/DONE if a new start is accepted in that cycle (back-to-back).
- A `start` while in CALC is ignored; there is no queuing. The upstream stall guarantees the request is re-presented.
- `flush`=1 in any state forces IDLE on the next edge, with no `done`. `r` keeps its previous value.
- When `start` and `flush` arrive in the same cycle, `flush` wins.
- `rst`=0 forces IDLE on the next edge regardless of state. After reset: `busy`=0, `done`=0, `r`=0, counter=0, internal P/Q=0.

## Timing
- `busy` = (state==CALC). It is combinational from the state register, so it is high from the cycle after acceptance through the 32nd CALC cycle.
- Normal latency: with start accepted in cycle N, CALC occupies N+1..N+32 and `done`/`r` are valid in N+33.
- Fast-path latency: `done`/`r` are valid in N+1, and `busy` is never asserted.
- All outputs are registered except `busy`. `r` updates only on the edge entering DONE.
- Throughput: one operation per 33 cycles on the normal path, or one per cycle on back-to-back fast-path requests.

## Test plan
- Reset: hold `rst`=0 for 3 cycles mid-CALC. Required: `busy`=0, `done`=0 and `r`=0 the cycle after; no `done` pulse afterwards.
- DIVU, `a`=100, `b`=7, start in cycle N. Required: `busy`=1 for N+1..N+32, `done`=1 with `r`=14 in N+33. REMU on the same operands gives `r`=2.
- Signed: DIV −7/2 gives `r`=0xFFFFFFFD (−3). REM −7/2 gives `r`=0xFFFFFFFF (−1). DIV 7/−2 gives 0xFFFFFFFD. REM 7/−2 gives 1.
- Fast paths, each with `done` in N+1 and `busy` never high:
  - DIVU 5/0 gives 0xFFFFFFFF.
  - REM 0xFFFFFFF6/0 gives 0xFFFFFFF6.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM 0x80000000/0xFFFFFFFF gives 0.
- Flush: start DIVU 100/7, assert `flush` in N+10. Required: IDLE and `busy`=0 in N+11, no `done`, `r` unchanged. `start` and `flush` in the same cycle are ignored.
- Back-to-back and ignore:
  - A `start` pulse in N+5 during CALC is ignored, and the result still arrives in N+33.
  - A new DIVU 0xFFFFFFFF/1 presented in the DONE cycle is accepted, and gives `done` with `r`=0xFFFFFFFF exactly 33 cycles later.

Source files
------------

// File: rtl/prv32_div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with single-cycle fast paths for divide-by-zero and signed overflow.
module prv32_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] r
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] p_q, p_d;
  logic [31:0] q_q, q_d;
  logic [31:0] d_q, d_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_rem_q, is_rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] r_q, r_d;
  logic        done_q, done_d;

  logic        is_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sh_p, trial;
  logic [31:0] step_p, step_q;

  // Partial remainder is always below the divisor, so 32 stored bits suffice; the 33rd bit
  // only exists in the shifted/trial value.
  always_comb begin
    sh_p   = {p_q, q_q[31]};
    trial  = sh_p - {1'b0, d_q};
    step_p = trial[32] ? sh_p[31:0] : trial[31:0];
    step_q = {q_q[30:0], ~trial[32]};
  end

  always_comb begin
    is_signed = ~op[0];
    a_mag     = (is_signed && a[31]) ? -a : a;
    b_mag     = (is_signed && b[31]) ? -b : b;
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    r_d       = r_q;

    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (start) begin
            is_rem_d  = op[1];
            neg_quo_d = is_signed & (a[31] ^ b[31]);
            neg_rem_d = is_signed & a[31];
            p_d       = '0;
            q_d       = a_mag;
            d_d       = b_mag;
            cnt_d     = '0;
            if (b == 32'd0) begin
              state_d = StDone;
              r_d     = op[1] ? a : 32'hFFFF_FFFF;
            end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              state_d = StDone;
              r_d     = op[1] ? 32'd0 : 32'h8000_0000;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          p_d   = step_p;
          q_d   = step_q;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StDone;
            if (is_rem_q) r_d = neg_rem_q ? -step_p : step_p;
            else          r_d = neg_quo_q ? -step_q : step_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      r_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      q_q       <= q_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      r_q       <= r_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == StCalc);
  assign done = done_q;
  assign r    = r_q;

endmodule
